// File: rtl/mips_pkg.sv
// Shared widths, reset default and queue-entry payload for the MIPS fetch path.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PC_INC  = 4;
  localparam int unsigned CNT_W   = 2;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the address that follows it.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_q2.sv
// Two-entry in-order queue between instruction memory and decode.
// Entry 0 is always the head, so the head outputs come straight from a register.
module fetch_q2
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  fetch_entry_t     din_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     e0_q, e0_d, e1_q, e1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for entries and occupancy; clear wins over push/pop.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = din_i;
          else               e1_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = din_i;
          end else begin
            e0_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;

`ifndef SYNTHESIS
  // The issue credit must never let a push land in a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && !clear_i && cnt_q == 2'd2))
    else $error("fetch_q2 overflow");

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && !clear_i && cnt_q == 2'd0))
    else $error("fetch_q2 underflow");
`endif

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC ownership, imem read issue, 2-deep output queue
// with valid/ready handshake to decode, and redirect flush.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
`endif
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  PCPlus4
);

  localparam int unsigned USED_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic              started_q;
  logic [CNT_W-1:0]  count;
  logic [USED_W-1:0] used;
  logic              pop, push, issue;
  fetch_entry_t      head, push_entry;

  // Slots already claimed; a same-cycle pop frees one so streaming keeps 1 instr/cycle.
  assign pop   = instr_valid & instr_ready;
  assign used  = USED_W'(count) - USED_W'(pop) + USED_W'(inflight_q);
  assign issue = started_q & ~redirect_valid & (used < USED_W'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  // In the response cycle pc_q has advanced exactly once past the issued address.
  assign push       = inflight_q & ~redirect_valid;
  assign push_entry = '{instr: imem_rdata, pcplus4: pc_q};

  // PC update: redirect beats sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = redirect_pc & ~ADDR_W'(3);
    else if (issue)      pc_d = pc_q + ADDR_W'(PC_INC);
  end

  // PC, in-flight flag and post-reset start flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      started_q  <= 1'b1;
    end
  end

  fetch_q2 u_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .din_i   (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign instr_valid = (count != '0);
  assign Instr       = head.instr;
  assign PCPlus4     = head.pcplus4;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, stall_q;

  // Saturating handshake and backpressure-stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (pop && fetched_q != '1)                         fetched_q <= fetched_q + 32'd1;
      if (instr_valid && !instr_ready && stall_q != '1)  stall_q   <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule
